intermediate_ram_reader: RTL
============================

Name: intermediate_ram_reader

Overview:
Read-side streaming engine for the intermediate activation RAM (negedge-registered read port, 14-bit address, signed 32-bit data, 4704 words). A start command carries a base address and a word count. The block issues sequential RAM reads and delivers the words on a valid/ready stream, absorbing the RAM's read latency and downstream backpressure. It sits between the intermediate RAM and the next layer's MAC datapath.

Parameters:
ADDR_W, 14, RAM address width
DATA_W, 32, signed data word width
DEPTH, 4704, number of RAM words; addresses wrap modulo DEPTH
FIFO_DEPTH, 2, output buffer entries; must be >= 2

Ports:
Clk  in  1  system clock; all state updates on posedge
Reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle command strobe; honoured only in IDLE
base_addr  in  ADDR_W  first word address; must be < DEPTH
length  in  ADDR_W  words to stream, 0..DEPTH
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the transfer completes
rdaddr  out  ADDR_W  RAM read address, registered
rddata  in  DATA_W  signed RAM read data
m_data  out  DATA_W  signed stream data = FIFO head
m_valid  out  1  stream data valid
m_ready  in  1  downstream ready
m_last  out  1  high with the final word of the transfer

Behaviour:
- Reset (Reset_n=0 at posedge): state=IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, rdaddr=0, FIFO emptied, in-flight read discarded, counters cleared. Reset mid-transfer aborts silently with no done pulse.
- RAM timing: rdaddr is driven from a register updated at posedge t. The RAM samples it at the following negedge. rddata is captured at posedge t+1, so read latency is 1 cycle. At most 1 read is in flight.
- FSM:
  - IDLE: on start with length=0, go to FIN. On start with length>0, latch the issue address (base_addr), issue count and delivery count (both = length), and go to RUN. start is ignored in every state except IDLE.
  - RUN: issue and deliver words (rules below). When the delivery count reaches 0 (the last handshake), go to FIN.
  - FIN: done=1 for exactly 1 cycle, busy=0, then go to IDLE. A start in FIN is ignored.
- Issue rule (RUN): issue when issue_cnt>0 and (fifo_count + inflight - pop) < FIFO_DEPTH.
  - pop = m_valid & m_ready in the current cycle.
  - An issue loads rdaddr with the next address, sets inflight for the next cycle, and decrements issue_cnt.
  - Address increments by 1; DEPTH-1 wraps to 0.
- Capture: inflight=1 pushes rddata into the FIFO at the next posedge. The rule above guarantees no overflow.
- Stream:
  - m_valid = FIFO not empty.
  - Handshake occurs when m_valid & m_ready.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - m_last=1 on the word whose handshake brings the delivery count to 0.
- Throughput and latency:
  - With m_ready held high: 1 word per cycle.
  - First m_valid appears 2 cycles after the start cycle (issue at start+1, capture at start+2).
  - done pulses the cycle after the last handshake.
- Simultaneous push and pop in the same cycle: both happen and fifo_count is unchanged.
- length=DEPTH: every word is read exactly once, wrapping through 0 when base_addr>0.
- Widths: counters are ADDR_W bits. No arithmetic is done on the data, which passes through bit-exact and signed.

Test Plan:
- Basic: mem[10..13]=1,-2,3,-4; start with base=10, length=4, m_ready=1 -> m_valid high on cycles s+2..s+5 with m_data 1,-2,3,-4; m_last only with -4; done at s+6; busy low at s+6.
- Backpressure: the same transfer with m_ready toggling 1,0,0,1,... -> no word lost or duplicated; m_data stable while stalled; rdaddr never more than FIFO_DEPTH words ahead of delivery.
- Wrap: base=4702, length=4, mem[4702]=7, [4703]=8, [0]=9, [1]=10 -> stream 7,8,9,10; rdaddr sequence 4702,4703,0,1.
- Zero length: start with length=0 -> done pulses at s+1; m_valid stays 0; busy never asserts.
- Start while busy: second start (base=100) mid-transfer -> ignored; original 4 words only; one done pulse.
- Reset mid-transfer: Reset_n=0 for 1 cycle after 2 handshakes -> m_valid=0, busy=0, done=0 the next cycle; a new start (base=0, length=2) then streams mem[0], mem[1] correctly.

Source files
------------

// File: rtl/intermediate_ram_reader.sv
// Streams a contiguous, wrapping window of the intermediate activation RAM onto a valid/ready bus.
// Absorbs the one-cycle RAM read latency with a small output FIFO so full throughput survives backpressure.
module intermediate_ram_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4704,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        rdaddr,
    input  logic signed [DATA_W-1:0] rddata,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                    state, state_nxt;
    logic [ADDR_W-1:0]         next_addr;
    logic [ADDR_W-1:0]         issue_cnt;
    logic [ADDR_W-1:0]         deliv_cnt;
    logic                      inflight;
    logic signed [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             fifo_count;
    logic                      accept;
    logic                      pop;
    logic                      push;
    logic                      issue;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign m_valid = (fifo_count != '0);
    assign m_data  = fifo_mem[rd_ptr];
    assign m_last  = m_valid && (deliv_cnt == ADDR_W'(1));
    assign pop     = m_valid & m_ready;
    assign push    = inflight;
    assign accept  = (state == IDLE) && start && (length != '0);

    // A slot freed by this cycle's pop may be claimed immediately, keeping one word per cycle.
    assign issue = (state == RUN) && (issue_cnt != '0) &&
                   ((32'(fifo_count) + 32'(inflight)) < (32'(FIFO_DEPTH) + 32'(pop)));

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (length == '0) ? FIN : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (pop && (deliv_cnt == ADDR_W'(1))) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The first read is issued on the accepting edge itself, so data lands two cycles after the start.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rdaddr     <= '0;
            next_addr  <= '0;
            issue_cnt  <= '0;
            deliv_cnt  <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            inflight <= 1'b0;
            if (accept) begin
                rdaddr    <= base_addr;
                next_addr <= addr_inc(base_addr);
                issue_cnt <= length - ADDR_W'(1);
                deliv_cnt <= length;
                inflight  <= 1'b1;
            end else if (issue) begin
                rdaddr    <= next_addr;
                next_addr <= addr_inc(next_addr);
                issue_cnt <= issue_cnt - ADDR_W'(1);
                inflight  <= 1'b1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= rddata;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                deliv_cnt <= deliv_cnt - ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
